// File: rtl/pipe_chain_if.sv
// Valid/ready stream bundle used on both ends of pipe_chain.
// The master drives valid/data; the slave drives ready.
interface pipe_chain_if #(
    parameter int unsigned DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: N-stage valid/ready register chain with per-stage stall,
// ranged flush (stages 0..K) and optional performance counters.
// Stage 0 is youngest, STAGES-1 oldest.
// Optional feature macro: PIPE_PERF_EN enables saturating stall/flush
// counters; when undefined the counter outputs are tied to zero.
module pipe_chain #(
    parameter  int unsigned STAGES = 5,
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned CNT_W  = 32,
    localparam int unsigned SEL_W  = $clog2(STAGES) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    pipe_chain_if.slave              in_if,
    pipe_chain_if.master             out_if,
    input  logic [STAGES-1:0]        i_stall,
    input  logic                     i_flush,
    input  logic [SEL_W-1:0]         i_flush_stage,
    output logic [STAGES-1:0]        o_stage_valid,
    output logic [STAGES*DATA_W-1:0] o_stage_data,
    output logic [SEL_W-1:0]         o_count,
    output logic [CNT_W-1:0]         o_perf_stall,
    output logic [CNT_W-1:0]         o_perf_flush
);

    logic [STAGES-1:0] valid_q;
    logic [DATA_W-1:0] data_q [STAGES];

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] up_v;
    logic [DATA_W-1:0] up_d [STAGES];
    logic [STAGES-1:0] kill;
    logic [SEL_W-1:0]  flush_k;

    // Clamp the flush range to the last stage and build the kill mask.
    always_comb begin
        flush_k = (i_flush_stage >= SEL_W'(STAGES)) ? SEL_W'(STAGES - 1) : i_flush_stage;
        kill    = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            kill[s] = i_flush && (SEL_W'(s) <= flush_k);
        end
    end

    // Ready chain, evaluated from the consumer back to the producer.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_if.ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            rdy[STAGES-1-i] = ~valid_q[STAGES-1-i]
                            | (~i_stall[STAGES-1-i] & rdy[STAGES-i]);
        end
    end

    // Upstream offer into each stage; a killed stage offers nothing, which
    // is what keeps flushed entries out of stage K+1.
    always_comb begin
        up_v    = '0;
        up_v[0] = in_if.valid;
        up_d[0] = in_if.data;
        for (int unsigned s = 1; s < STAGES; s++) begin
            up_v[s] = valid_q[s-1] & ~i_stall[s-1] & ~kill[s-1];
            up_d[s] = data_q[s-1];
        end
    end

    // Stage registers: flush beats load, load only when ready, else hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (kill[s]) begin
                    valid_q[s] <= 1'b0;
                end else if (rdy[s]) begin
                    valid_q[s] <= up_v[s];
                end
                if (rdy[s] && up_v[s] && !kill[s]) begin
                    data_q[s] <= up_d[s];
                end
            end
        end
    end

    assign in_if.ready  = rdy[0];
    assign out_if.valid = valid_q[STAGES-1] & ~i_stall[STAGES-1];
    assign out_if.data  = data_q[STAGES-1];

    // Per-stage visibility for bypass/hazard logic and occupancy count.
    always_comb begin
        o_stage_valid = valid_q;
        o_stage_data  = '0;
        o_count       = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            o_stage_data[s*DATA_W +: DATA_W] = data_q[s];
            o_count = o_count + SEL_W'(valid_q[s]);
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             stall_any;
    logic [SEL_W:0]   killed_n;
    logic [CNT_W:0]   flush_sum;

    // Count killed valid stages plus an input accepted during the flush.
    always_comb begin
        stall_any = |(valid_q & i_stall);
        killed_n  = (SEL_W+1)'(i_flush & in_if.valid & rdy[0]);
        for (int unsigned s = 0; s < STAGES; s++) begin
            killed_n = killed_n + (SEL_W+1)'(valid_q[s] & kill[s]);
        end
        flush_sum = {1'b0, flush_cnt_q} + (CNT_W+1)'(killed_n);
    end

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_any && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            flush_cnt_q <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        end
    end

    assign o_perf_stall = stall_cnt_q;
    assign o_perf_flush = flush_cnt_q;
`else
    assign o_perf_stall = '0;
    assign o_perf_flush = '0;
`endif

endmodule
